aes_cmd_sequencer: RTL and testbench
====================================

Name: aes_cmd_sequencer

Overview:
- Command sequencer between the UART frame core and the AES encryption core.
- Decodes validated 18-byte UART frames into key/plaintext loads, encrypt starts, result readback and status queries.
- Drives the AES core's ld/done handshake with a timeout.
- Schedules reply frames into the UART TX path, honouring TX busy.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed from aes_ld to aes_done before timeout error
CNT_W, 8, width of saturating drop counter

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
rx_frame  in  144  received frame; byte k = bits [8k+7:8k]
rx_valid  in  1  one-cycle strobe: rx_frame holds a new frame
tx_frame  out  144  reply frame to UART TX
tx_send  out  1  one-cycle pulse: transmit tx_frame
tx_busy  in  1  UART TX occupied; no tx_send while high
aes_key  out  128  key to AES core
aes_text_in  out  128  plaintext to AES core
aes_ld  out  1  one-cycle start pulse to AES core
aes_done  in  1  one-cycle completion strobe from AES core
aes_text_out  in  128  ciphertext, valid when aes_done
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag
drop_cnt  out  CNT_W  saturating count of rejected frames

Behaviour:
- Reset, asynchronous: every register and output = 0; state = IDLE; result register and result_valid = 0.
- Frame check: valid only if byte17 == byte0; cmd = byte0; payload = rx_frame[135:8], byte16 is the MSB.
- Frames are sampled only when rx_valid = 1 and state = IDLE.
- drop_cnt increments by 1 (saturating at 2^CNT_W-1) on each of:
  - rx_valid in a non-IDLE state;
  - byte17 != byte0;
  - unknown cmd.
- Commands, accepted in IDLE:
  - 'C': aes_key <= payload. Stays IDLE.
  - 'D': aes_text_in <= payload. Stays IDLE.
  - 'E': result_valid <= 0. Next cycle aes_ld = 1 for exactly one cycle; state LOAD -> WAIT.
  - 'B': reply = {"B", result, "B"} if result_valid, else {"!", 128'h0, "!"}. State REPLY.
  - 'S': reply = {"S", 112'h0, drop_cnt zero-extended to 8b in byte2, {5'b0, busy, result_valid, err} in byte1, "S"}. State REPLY.
  - 'X': err <= 0; drop_cnt <= 0. Stays IDLE.
- States and transitions:
  - IDLE: waits for a frame.
  - LOAD: aes_ld = 1 for this single cycle; timeout counter <= 0; -> WAIT.
  - WAIT: counter increments each cycle.
    - aes_done = 1: result <= aes_text_out; result_valid <= 1; -> IDLE.
    - Else if counter == TIMEOUT_CYCLES-1: err <= 1; -> IDLE.
    - aes_done and timeout in the same cycle: done wins, err unchanged.
  - REPLY: tx_frame is registered on entry. tx_send = 1 in the first cycle with tx_busy = 0, then -> IDLE. tx_frame holds its value until the next REPLY entry.
- aes_key and aes_text_in stay stable through LOAD and WAIT, because C/D frames are rejected when not IDLE.
- rx_valid together with aes_done in WAIT: done is processed; the frame is dropped and counted.
- Reset asserted mid-WAIT: the pending result is discarded and no aes_ld is reissued.
- Latency:
  - 'E' accepted at cycle t: aes_ld at t+1.
  - 'B'/'S' accepted at cycle t: tx_send at t+1 at the earliest.

Optional Feature:
AES_SEQ_AUTO_REPLY_EN
- Defined: on aes_done in WAIT, capture the result as normal, then go to REPLY with {"B", aes_text_out, "B"}. No separate 'B' command is needed.
- Timeout still returns to IDLE with no reply.
- Undefined: WAIT returns directly to IDLE on done; no automatic transmission.

Test Plan:
1. Load and encrypt:
   - Stimulus: 'C' with key 000102030405060708090a0b0c0d0e0f, 'D' with 00112233445566778899aabbccddeeff, 'E'; core model raises aes_done 20 cycles after aes_ld with 69c4e0d86a7b0430d8cdb78070b4c55a.
   - Expected: aes_key and aes_text_in match the payloads; aes_ld is a single pulse one cycle after 'E'; a subsequent 'B' gives tx_frame = {"B", 69c4...c55a, "B"} and one tx_send.
2. Timeout:
   - Stimulus: 'E' with no aes_done.
   - Expected: err = 1 exactly TIMEOUT_CYCLES cycles after aes_ld; 'B' replies {"!", 0, "!"}; 'S' reports byte1 = 8'h01; 'X' clears err.
3. Rejected frames:
   - Stimulus: frame with byte17 = "Z", byte0 = "C"; then 'C' sent during WAIT.
   - Expected: aes_key unchanged; drop_cnt = 2.
   - Stimulus: 300 bad frames.
   - Expected: drop_cnt saturates at 255.
4. TX backpressure:
   - Stimulus: 'S' with tx_busy held high for 10 cycles.
   - Expected: no tx_send while tx_busy is high; exactly one tx_send in the first cycle after it falls; tx_frame bytes 0 and 17 = "S".
5. Simultaneous events:
   - Stimulus: aes_done and rx_valid('C') in the same cycle, and aes_done on the timeout cycle.
   - Expected: result is captured, err = 0, drop_cnt increments by 1.
6. Reset mid-operation:
   - Stimulus: drive rst low during WAIT.
   - Expected: all outputs 0 immediately; after release, 'B' replies "!".
   - With AES_SEQ_AUTO_REPLY_EN: case 1 produces tx_send without a 'B' command.

Source files
------------

// File: rtl/aes_cmd_sequencer.sv
// rtl/aes_cmd_sequencer.sv - UART frame command sequencer driving the AES core ld/done handshake.
// Optional AES_SEQ_AUTO_REPLY_EN: send the ciphertext reply automatically when the core finishes.
module aes_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [143:0]   rx_frame,
  input  logic           rx_valid,
  output logic [143:0]   tx_frame,
  output logic           tx_send,
  input  logic           tx_busy,
  output logic [127:0]   aes_key,
  output logic [127:0]   aes_text_in,
  output logic           aes_ld,
  input  logic           aes_done,
  input  logic [127:0]   aes_text_out,
  output logic           busy,
  output logic           err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_REPLY = 2'd3;

  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_X    = 8'h58;
  localparam logic [7:0] CH_NONE = 8'h21;

  logic [1:0]       state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [127:0]     result;
  logic             result_valid;

  logic [7:0]   cmd;
  logic [7:0]   tail;
  logic [127:0] payload;
  logic         cmd_known;
  logic         accept;
  logic         drop;
  logic [7:0]   cnt8;
  logic [7:0]   status8;

  assign cmd     = rx_frame[7:0];
  assign tail    = rx_frame[143:136];
  assign payload = rx_frame[135:8];

  always_comb begin
    cmd_known = 1'b0;
    case (cmd)
      CH_C, CH_D, CH_E, CH_B, CH_S, CH_X: cmd_known = 1'b1;
      default:                            cmd_known = 1'b0;
    endcase
  end

  // Any strobe that is not a well-formed, known command seen in IDLE is counted as a drop.
  assign accept  = rx_valid && (state == S_IDLE) && (tail == cmd) && cmd_known;
  assign drop    = rx_valid && !accept;

  assign cnt8    = 8'(drop_cnt);
  assign status8 = {5'b0, busy, result_valid, err};

  assign busy    = (state != S_IDLE);
  assign aes_ld  = (state == S_LOAD);
  assign tx_send = (state == S_REPLY) && !tx_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      drop_cnt     <= '0;
      aes_key      <= '0;
      aes_text_in  <= '0;
      tx_frame     <= '0;
    end else begin
      if (accept && (cmd == CH_X)) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd)
              CH_C: aes_key     <= payload;
              CH_D: aes_text_in <= payload;
              CH_E: begin
                result_valid <= 1'b0;
                state        <= S_LOAD;
              end
              CH_B: begin
                tx_frame <= result_valid ? {CH_B, result, CH_B} : {CH_NONE, 128'h0, CH_NONE};
                state    <= S_REPLY;
              end
              CH_S: begin
                tx_frame <= {CH_S, 112'h0, cnt8, status8, CH_S};
                state    <= S_REPLY;
              end
              CH_X: err <= 1'b0;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // Completion takes priority over a timeout landing on the same cycle.
          if (aes_done) begin
            result       <= aes_text_out;
            result_valid <= 1'b1;
`ifdef AES_SEQ_AUTO_REPLY_EN
            tx_frame     <= {CH_B, aes_text_out, CH_B};
            state        <= S_REPLY;
`else
            state        <= S_IDLE;
`endif
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_REPLY: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// tb/tb_aes_cmd_sequencer.sv - self-checking bench with a command-level reference model.
module tb_aes_cmd_sequencer;

  logic         clk;
  logic         rst;
  logic [143:0] rx_frame;
  logic         rx_valid;
  logic [143:0] tx_frame;
  logic         tx_send;
  logic         tx_busy;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic         aes_ld;
  logic         aes_done;
  logic [127:0] aes_text_out;
  logic         busy;
  logic         err;
  logic [7:0]   drop_cnt;

  aes_cmd_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_frame(rx_frame), .rx_valid(rx_valid),
    .tx_frame(tx_frame), .tx_send(tx_send), .tx_busy(tx_busy),
    .aes_key(aes_key), .aes_text_in(aes_text_in), .aes_ld(aes_ld),
    .aes_done(aes_done), .aes_text_out(aes_text_out), .busy(busy),
    .err(err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ld_pulses = 0;
  int tx_pulses = 0;
  int tx_while_busy = 0;

  always @(negedge clk) begin
    if (aes_ld === 1'b1) ld_pulses++;
    if (tx_send === 1'b1) tx_pulses++;
    if (tx_send === 1'b1 && tx_busy === 1'b1) tx_while_busy++;
  end

  // Reference model state, updated per command
  logic [127:0] m_key, m_text, m_result;
  bit           m_rv, m_err;
  int           m_drop;
  logic [143:0] m_reply;
  int           e_ld = 0;
  int           e_tx = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit known(input logic [7:0] c);
    return (c == "C" || c == "D" || c == "E" || c == "B" || c == "S" || c == "X");
  endfunction

  function automatic logic [143:0] status_reply();
    logic [7:0] bytes [18];
    logic [143:0] f;
    for (int i = 0; i < 18; i++) bytes[i] = 8'h00;
    bytes[0]  = "S";
    bytes[17] = "S";
    bytes[1]  = {6'b0, m_rv, m_err};
    bytes[2]  = 8'(m_drop);
    for (int i = 0; i < 18; i++) f[8*i +: 8] = bytes[i];
    return f;
  endfunction

  task automatic model_apply(input logic [7:0] c, input logic [127:0] p, input logic [7:0] t, input bit idle);
    if (!idle || t != c || !known(c)) begin
      if (m_drop < 255) m_drop++;
    end else begin
      case (c)
        "C": m_key = p;
        "D": m_text = p;
        "E": begin m_rv = 0; e_ld++; end
        "B": begin
          m_reply = m_rv ? {8'h42, m_result, 8'h42} : {8'h21, 128'h0, 8'h21};
          e_tx++;
        end
        "S": begin m_reply = status_reply(); e_tx++; end
        "X": begin m_err = 0; m_drop = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [127:0] p, input logic [7:0] t, input bit idle);
    rx_frame = {t, p, c};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    model_apply(c, p, t, idle);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_key"}, 144'(aes_key), 144'(m_key));
    chk({tag, "_text"}, 144'(aes_text_in), 144'(m_text));
    chk({tag, "_err"}, 144'(err), 144'(m_err));
    chk({tag, "_drop"}, 144'(drop_cnt), 144'(m_drop));
  endtask

  task automatic reply_check(input string tag);
    chk({tag, "_send"}, 144'(tx_send), 144'(1'b1));
    chk({tag, "_frame"}, tx_frame, m_reply);
    step();
    chk({tag, "_idle"}, 144'(busy), 144'(1'b0));
  endtask

  task automatic after_done();
`ifdef AES_SEQ_AUTO_REPLY_EN
    m_reply = {8'h42, m_result, 8'h42};
    e_tx++;
    reply_check("auto_reply");
`else
    chk("done_idle", 144'(busy), 144'(1'b0));
`endif
  endtask

  // 'E' then aes_done raised lat cycles after the aes_ld cycle
  task automatic encrypt(input int lat, input logic [127:0] ct);
    send("E", 128'h0, "E", 1);
    chk("ld_pulse", 144'(aes_ld), 144'(1'b1));
    step();
    chk("ld_single", 144'(aes_ld), 144'(1'b0));
    repeat (lat - 1) step();
    chk("wait_busy", 144'(busy), 144'(1'b1));
    aes_done = 1'b1;
    aes_text_out = ct;
    step();
    aes_done = 1'b0;
    aes_text_out = {4{$urandom}};
    m_result = ct;
    m_rv = 1;
    after_done();
  endtask

  task automatic do_reset();
    m_key = '0; m_text = '0; m_result = '0; m_rv = 0; m_err = 0; m_drop = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] k, p, ct;
    logic [7:0] c, t;
    rst = 1'b0; rx_frame = '0; rx_valid = 1'b0; tx_busy = 1'b0;
    aes_done = 1'b0; aes_text_out = '0;
    do_reset();
    step(); step();
    chk("rst_tx_frame", tx_frame, 144'h0);
    chk("rst_outs", 144'({tx_send, aes_ld, busy, err}), 144'h0);
    check_model("rst");
    rst = 1'b1;
    step();

    // 1: load and encrypt with the reference vector
    send("C", 128'h000102030405060708090a0b0c0d0e0f, "C", 1);
    send("D", 128'h00112233445566778899aabbccddeeff, "D", 1);
    check_model("load");
    encrypt(20, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    send("B", 128'h0, "B", 1);
    reply_check("b_reply");
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      send("C", k, "C", 1);
      send("D", p, "D", 1);
      encrypt(int'($urandom_range(1, 63)), ct);
      send("B", 128'h0, "B", 1);
      reply_check("rand_b_reply");
      check_model("rand_load");
    end

    // 2: timeout
    send("E", 128'h0, "E", 1);
    chk("tmo_ld", 144'(aes_ld), 144'(1'b1));
    repeat (64) step();
    chk("tmo_err_early", 144'({busy, err}), 144'(2'b10));
    step();
    m_err = 1;
    chk("tmo_err_set", 144'({busy, err}), 144'(2'b01));
    send("B", 128'h0, "B", 1);
    reply_check("tmo_b_none");
    send("S", 128'h0, "S", 1);
    chk("tmo_s_byte1", 144'(tx_frame[15:8]), 144'(8'h01));
    reply_check("tmo_s_reply");
    send("X", 128'h0, "X", 1);
    check_model("x_clear");

    // 3: rejected frames and saturation
    send("C", {4{$urandom}}, "Z", 1);
    send("E", 128'h0, "E", 1);
    step();
    send("C", {4{$urandom}}, "C", 0);
    repeat (5) step();
    aes_done = 1'b1; ct = {4{$urandom}}; aes_text_out = ct;
    step();
    aes_done = 1'b0; m_result = ct; m_rv = 1;
    after_done();
    check_model("reject2");
    for (int i = 0; i < 300; i++) begin
      c = 8'($urandom);
      if (i % 2 == 0) begin
        t = c ^ 8'($urandom_range(1, 255));
      end else begin
        while (known(c)) c = 8'($urandom);
        t = c;
      end
      send(c, {4{$urandom}}, t, 1);
    end
    check_model("saturate");
    send("X", 128'h0, "X", 1);
    chk("sat_clear", 144'(drop_cnt), 144'(0));

    // 4: TX backpressure
    tx_busy = 1'b1;
    send("S", 128'h0, "S", 1);
    repeat (10) begin
      chk("bp_hold", 144'({tx_send, busy}), 144'(2'b01));
      step();
    end
    tx_busy = 1'b0;
    #1;
    chk("bp_tag", 144'({tx_frame[143:136], tx_frame[7:0]}), 144'(16'h5353));
    reply_check("bp_reply");

    // 5: done together with a frame, and done on the timeout cycle
    send("E", 128'h0, "E", 1);
    step();
    repeat (int'($urandom_range(0, 30))) step();
    aes_done = 1'b1; ct = {4{$urandom}}; aes_text_out = ct;
    rx_frame = {8'h43, {4{$urandom}}, 8'h43}; rx_valid = 1'b1;
    step();
    aes_done = 1'b0; rx_valid = 1'b0;
    m_result = ct; m_rv = 1;
    model_apply("C", 128'h0, "C", 0);
    after_done();
    check_model("done_rx");
    send("B", 128'h0, "B", 1);
    reply_check("done_rx_b");
    encrypt(64, {4{$urandom}});
    check_model("done_tmo");
    send("B", 128'h0, "B", 1);
    reply_check("done_tmo_b");

    // 6: reset in WAIT
    send("C", {4{$urandom}}, "C", 1);
    send("E", 128'h0, "E", 1);
    repeat (5) step();
    rst = 1'b0;
    #1;
    do_reset();
    chk("mid_rst_frame", tx_frame, 144'h0);
    chk("mid_rst_outs", 144'({tx_send, aes_ld, busy, err}), 144'h0);
    check_model("mid_rst");
    step();
    rst = 1'b1;
    repeat (8) step();
    send("B", 128'h0, "B", 1);
    reply_check("rst_b_none");

    chk("ld_count", 144'(ld_pulses), 144'(e_ld));
    chk("tx_count", 144'(tx_pulses), 144'(e_tx));
    chk("tx_vs_busy", 144'(tx_while_busy), 144'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
